// File: rtl/input_capture_timer_pkg.sv
// Shared types for the input capture timer: FSM state encoding and default widths.
package input_capture_timer_pkg;

   localparam int DEF_CNT_WIDTH   = 16;
   localparam int DEF_PRESC_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2
   } ict_state_e;

endpackage

// File: rtl/input_capture_timer_if.sv
// Result handshake between the capture timer (master) and its consumer (slave).
interface input_capture_timer_if
   import input_capture_timer_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
   logic [CNT_WIDTH-1:0] period_out;
   logic                 period_valid;
   logic                 overflow;
   logic                 overrun;
   logic                 capture_ack;

   modport master (
      output period_out, period_valid, overflow, overrun,
      input  capture_ack
   );

   modport slave (
      input  period_out, period_valid, overflow, overrun,
      output capture_ack
   );
endinterface

// File: rtl/input_capture_timer_cap_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus one-cycle rising-edge pulse.
module input_capture_timer_cap_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o
);
   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/input_capture_timer.sv
// Measures the period between rising edges of cap_in_i in prescaled ticks.
//   state      | meaning
//   ST_IDLE    | disabled, counters held at zero
//   ST_ARMED   | enabled, waiting for the first rising edge
//   ST_MEASURE | counting ticks; each rising edge captures and restarts
module input_capture_timer
   import input_capture_timer_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic [PRESC_WIDTH-1:0] prescaler_i,
   input  logic                   cap_in_i,
   input_capture_timer_if.master  res_if
);
   ict_state_e             state_q, state_d;
   logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
   logic [PRESC_WIDTH-1:0] presc_lat_q, presc_lat_d;
   logic [CNT_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
   logic                   ovf_int_q, ovf_int_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic                   ovf_out_q, ovf_out_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;

   logic                   rise;
   logic [PRESC_WIDTH-1:0] step_presc;
   logic [CNT_WIDTH-1:0]   step_tick;
   logic                   step_ovf;
   logic                   capture, restart;

   input_capture_timer_cap_sync_edge u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sig_i  (cap_in_i),
      .rise_o (rise)
   );

   always_comb begin
      state_d     = state_q;
      presc_cnt_d = presc_cnt_q;
      presc_lat_d = presc_lat_q;
      tick_cnt_d  = tick_cnt_q;
      ovf_int_d   = ovf_int_q;
      period_d    = period_q;
      ovf_out_d   = ovf_out_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      capture     = 1'b0;
      restart     = 1'b0;
      step_presc  = presc_cnt_q + 1'b1;
      step_tick   = tick_cnt_q;
      step_ovf    = ovf_int_q;

      // The edge cycle itself counts, so the captured value is the post-step count.
      if (presc_cnt_q == presc_lat_q) begin
         step_presc = '0;
         if (tick_cnt_q == '1) begin
            step_ovf = 1'b1;
         end else begin
            step_tick = tick_cnt_q + 1'b1;
         end
      end

      if (res_if.capture_ack && valid_q) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            presc_cnt_d = '0;
            tick_cnt_d  = '0;
            ovf_int_d   = 1'b0;
            if (enable_i) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (rise) begin
               state_d = ST_MEASURE;
               restart = 1'b1;
            end
         end
         ST_MEASURE: begin
            if (!enable_i) begin
               state_d     = ST_IDLE;
               presc_cnt_d = '0;
               tick_cnt_d  = '0;
               ovf_int_d   = 1'b0;
            end else if (rise) begin
               capture = 1'b1;
               restart = 1'b1;
            end else begin
               presc_cnt_d = step_presc;
               tick_cnt_d  = step_tick;
               ovf_int_d   = step_ovf;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (restart) begin
         presc_cnt_d = '0;
         tick_cnt_d  = '0;
         ovf_int_d   = 1'b0;
         presc_lat_d = prescaler_i;
      end

      // An unacknowledged sample is never overwritten; the lost edge is flagged instead.
      if (capture) begin
         if (!valid_q || res_if.capture_ack) begin
            period_d  = step_tick;
            ovf_out_d = step_ovf;
            valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         presc_cnt_q <= '0;
         presc_lat_q <= '0;
         tick_cnt_q  <= '0;
         ovf_int_q   <= 1'b0;
         period_q    <= '0;
         ovf_out_q   <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_cnt_q <= presc_cnt_d;
         presc_lat_q <= presc_lat_d;
         tick_cnt_q  <= tick_cnt_d;
         ovf_int_q   <= ovf_int_d;
         period_q    <= period_d;
         ovf_out_q   <= ovf_out_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign res_if.period_out   = period_q;
   assign res_if.period_valid = valid_q;
   assign res_if.overflow     = ovf_out_q;
   assign res_if.overrun      = overrun_q;
endmodule
